softmax_ctrl: RTL and testbench

SOFTMAX_CTRL -- requirements
Module: softmax_ctrl

---
 rtl/nn_pkg.sv | 17 +
 rtl/sm_score_buf.sv | 24 ++
 rtl/softmax_ctrl.sv | 171 +++++++++++++++++
 tb/tb_softmax_ctrl.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// Shared FSM state type, Q16.16 constants and default data width for the
// softmax controller and its score buffer.
package nn_pkg;
    localparam int NN_DATA_W = 32;

    localparam logic [NN_DATA_W-1:0] ONE  = 32'h0001_0000;
    localparam logic [NN_DATA_W-1:0] HALF = 32'h0000_8000;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        FEED,
        WAIT_MAX,
        BACK,
        DONE
    } sm_state_e;
endpackage

// File: rtl/sm_score_buf.sv
// Class-score storage: one synchronous write port, one asynchronous read port.
// Contents are not reset; every entry is written before it is read.
module sm_score_buf #(
    parameter int N_CLASSES = 4,
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 2
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [N_CLASSES];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/softmax_ctrl.sv
// Sequences one softmax run: load scores, feed them, read argmax, optionally
// stream backprop errors. Define SOFTMAX_CTRL_STATS_EN for run/correct counters.
module softmax_ctrl
    import nn_pkg::*;
#(
    parameter int N_CLASSES = 4,
    parameter int IDX_W     = 3,
    parameter int DATA_W    = NN_DATA_W,
    parameter int TIMEOUT   = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run_start,
    input  logic              train,
    input  logic [IDX_W-1:0]  label,
    input  logic              score_valid,
    output logic              score_ready,
    input  logic [DATA_W-1:0] score_data,
    output logic              sf_start,
    output logic              sf_backprop_ctrl,
    output logic [DATA_W-1:0] sf_input,
    output logic [IDX_W-1:0]  sf_input_idx,
    output logic [IDX_W-1:0]  sf_expected_label,
    input  logic              sf_in_ready,
    input  logic              sf_max_ready,
    input  logic              sf_out_ready,
    input  logic [IDX_W-1:0]  sf_max,
    input  logic [IDX_W-1:0]  sf_out_idx,
    input  logic [DATA_W-1:0] sf_out_data,
    output logic              err_valid,
    output logic [IDX_W-1:0]  err_idx,
    output logic [DATA_W-1:0] err_data,
    output logic              pred_valid,
    output logic [IDX_W-1:0]  pred,
    output logic              correct,
    output logic              timeout,
    output logic              busy
`ifdef SOFTMAX_CTRL_STATS_EN
    ,
    output logic [15:0]       run_count,
    output logic [15:0]       correct_count
`endif
);
    localparam int AW   = (N_CLASSES > 1) ? $clog2(N_CLASSES) : 1;
    localparam int WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [IDX_W-1:0] LAST   = IDX_W'(N_CLASSES - 1);
    localparam logic [WD_W-1:0]  WD_MAX = WD_W'(TIMEOUT);

    sm_state_e         state, state_nxt;
    logic [IDX_W-1:0]  load_cnt, idx, label_q;
    logic              train_q, start_q;
    logic [WD_W-1:0]   wd_cnt;
    logic [DATA_W-1:0] rd_data;
    logic              load_beat, wd_hit, wd_clr;

    sm_score_buf #(
        .N_CLASSES (N_CLASSES),
        .DATA_W    (DATA_W),
        .ADDR_W    (AW)
    ) u_buf (
        .clk   (clk),
        .we    (load_beat),
        .waddr (load_cnt[AW-1:0]),
        .wdata (score_data),
        .raddr (idx[AW-1:0]),
        .rdata (rd_data)
    );

    assign wd_hit = (state inside {FEED, WAIT_MAX, BACK}) && (wd_cnt == WD_MAX);

    always_comb begin
        state_nxt = state;
        sf_start  = 1'b0;
        load_beat = 1'b0;
        case (state)
            IDLE: if (run_start) state_nxt = LOAD;
            LOAD: begin
                load_beat = score_valid;
                if (score_valid && load_cnt == LAST) state_nxt = FEED;
            end
            FEED: begin
                // start drops for one cycle after every transfer
                sf_start = sf_in_ready && !start_q && !wd_hit;
                if (wd_hit) state_nxt = DONE;
                else if (sf_start && idx == LAST) state_nxt = WAIT_MAX;
            end
            WAIT_MAX: begin
                if (wd_hit) state_nxt = DONE;
                else if (sf_max_ready) state_nxt = train_q ? BACK : DONE;
            end
            BACK: begin
                sf_start = sf_out_ready && !wd_hit;
                if (wd_hit) state_nxt = DONE;
                else if (sf_start && sf_out_idx == LAST) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // watchdog restarts on entry to any softmax wait state and on every transfer
    assign wd_clr = sf_start ||
                    ((state_nxt != state) && (state_nxt inside {FEED, WAIT_MAX, BACK}));

    assign score_ready       = (state == LOAD);
    assign busy              = (state != IDLE);
    assign sf_backprop_ctrl  = (state == BACK);
    assign pred_valid        = (state == DONE);
    assign err_valid         = (state == BACK) && sf_start;
    assign err_idx           = err_valid ? sf_out_idx : '0;
    assign err_data          = err_valid ? sf_out_data : '0;
    assign sf_input          = (state == FEED) ? rd_data : '0;
    assign sf_input_idx      = idx;
    assign sf_expected_label = label_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            load_cnt <= '0;
            idx      <= '0;
            label_q  <= '0;
            train_q  <= 1'b0;
            start_q  <= 1'b0;
            wd_cnt   <= '0;
            pred     <= '0;
            correct  <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            state   <= state_nxt;
            start_q <= sf_start;
            if (wd_clr) wd_cnt <= '0;
            else if (wd_cnt != WD_MAX) wd_cnt <= wd_cnt + 1'b1;

            if (state == IDLE && run_start) begin
                train_q  <= train;
                label_q  <= label;
                load_cnt <= '0;
                idx      <= '0;
                correct  <= 1'b0;
                timeout  <= 1'b0;
            end
            if (load_beat && load_cnt != LAST) load_cnt <= load_cnt + 1'b1;
            if (state == FEED && sf_start && idx != LAST) idx <= idx + 1'b1;

            if (state == WAIT_MAX && sf_max_ready && !wd_hit) begin
                pred    <= sf_max;
                correct <= (sf_max == label_q);
            end
            if (wd_hit) begin
                timeout <= 1'b1;
                correct <= 1'b0;
            end
        end
    end

`ifdef SOFTMAX_CTRL_STATS_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_count     <= '0;
            correct_count <= '0;
        end else if (state == DONE) begin
            run_count <= sat_inc(run_count);
            if (correct && !timeout) correct_count <= sat_inc(correct_count);
        end
    end
`endif
endmodule

// File: tb/tb_softmax_ctrl.sv
// Self-checking bench for softmax_ctrl: directed scenarios plus randomized runs
// against a run-level reference model (argmax, transfer order, error echo).
module tb_softmax_ctrl;
    localparam int N  = 4;
    localparam int IW = 3;
    localparam int DW = 32;
    localparam int TO = 255;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, run_start, train, score_valid, score_ready;
    logic [IW-1:0] label, sf_input_idx, sf_expected_label, sf_max, sf_out_idx;
    logic [IW-1:0] err_idx, pred;
    logic [DW-1:0] score_data, sf_input, sf_out_data, err_data;
    logic          sf_start, sf_backprop_ctrl, sf_in_ready, sf_max_ready, sf_out_ready;
    logic          err_valid, pred_valid, correct, timeout, busy;
`ifdef SOFTMAX_CTRL_STATS_EN
    logic [15:0]   run_count, correct_count;
    int            exp_runs = 0, exp_correct = 0;
`endif

    softmax_ctrl #(.N_CLASSES(N), .IDX_W(IW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .run_start(run_start), .train(train), .label(label),
        .score_valid(score_valid), .score_ready(score_ready), .score_data(score_data),
        .sf_start(sf_start), .sf_backprop_ctrl(sf_backprop_ctrl), .sf_input(sf_input),
        .sf_input_idx(sf_input_idx), .sf_expected_label(sf_expected_label),
        .sf_in_ready(sf_in_ready), .sf_max_ready(sf_max_ready), .sf_out_ready(sf_out_ready),
        .sf_max(sf_max), .sf_out_idx(sf_out_idx), .sf_out_data(sf_out_data),
        .err_valid(err_valid), .err_idx(err_idx), .err_data(err_data),
        .pred_valid(pred_valid), .pred(pred), .correct(correct), .timeout(timeout),
        .busy(busy)
`ifdef SOFTMAX_CTRL_STATS_EN
        , .run_count(run_count), .correct_count(correct_count)
`endif
    );

    int            tests = 0;
    int            fails = 0;
    logic [DW-1:0] sc [N];
    logic [IW-1:0] cur_label;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference argmax over signed Q16.16 scores, first index wins ties
    function automatic int argmax();
        int m = 0;
        for (int i = 1; i < N; i++)
            if ($signed(sc[i]) > $signed(sc[m])) m = i;
        return m;
    endfunction

    task automatic chk_reset_outputs(input string p);
        chk({p, "_sf_start"}, sf_start, 0);
        chk({p, "_backprop"}, sf_backprop_ctrl, 0);
        chk({p, "_score_ready"}, score_ready, 0);
        chk({p, "_err_valid"}, err_valid, 0);
        chk({p, "_pred_valid"}, pred_valid, 0);
        chk({p, "_busy"}, busy, 0);
        chk({p, "_timeout"}, timeout, 0);
        chk({p, "_correct"}, correct, 0);
        chk({p, "_pred"}, pred, 0);
        chk({p, "_err_idx"}, err_idx, 0);
        chk({p, "_err_data"}, err_data, 0);
        chk({p, "_sf_input"}, sf_input, 0);
        chk({p, "_sf_input_idx"}, sf_input_idx, 0);
        chk({p, "_label"}, sf_expected_label, 0);
    endtask

    task automatic start_run(input bit tr, input logic [IW-1:0] lab);
        run_start = 1; train = tr; label = lab; cur_label = lab;
        #1;
        chk("idle_busy", busy, 0);
        tick();
        run_start = 0; train = ~tr; label = ~lab;
    endtask

    task automatic load_scores();
        for (int i = 0; i < N; i++) begin
            int g = $urandom_range(0, 2);
            for (int j = 0; j <= g; j++) begin
                score_valid = (j == g);
                score_data  = (j == g) ? sc[i] : DW'($urandom);
                #1;
                chk("load_ready", score_ready, 1);
                chk("load_label", sf_expected_label, cur_label);
                tick();
            end
        end
        score_valid = 0;
    endtask

    task automatic feed(input bit poke);
        int n = 0, cyc = 0;
        bit prev = 0;
        while (n < N && cyc < 200) begin
            sf_in_ready = ($urandom_range(0, 3) != 0);
            run_start   = poke && (cyc == 1);
            score_valid = poke;
            #1;
            chk("feed_start", sf_start, sf_in_ready && !prev);
            chk("feed_score_ready", score_ready, 0);
            chk("feed_pred_valid", pred_valid, 0);
            if (sf_start && sf_in_ready) begin
                chk("feed_idx", sf_input_idx, n);
                chk("feed_data", sf_input, sc[n]);
                n++;
            end
            prev = sf_start;
            tick();
            cyc++;
        end
        run_start = 0;
        chk("feed_count", n, N);
    endtask

    task automatic wait_max(input int am, input bit poke);
        int d = $urandom_range(0, 4);
        for (int j = 0; j <= d; j++) begin
            sf_in_ready  = $urandom_range(0, 1);
            sf_max_ready = (j == d);
            sf_max       = (j == d) ? IW'(am) : IW'($urandom);
            score_valid  = poke;
            #1;
            chk("wm_sf_start", sf_start, 0);
            chk("wm_backprop", sf_backprop_ctrl, 0);
            chk("wm_score_ready", score_ready, 0);
            chk("wm_pred_valid", pred_valid, 0);
            tick();
        end
        sf_max_ready = 0; sf_in_ready = 0; score_valid = 0;
    endtask

    // Returns 1 when the run was aborted by reset after abort_after beats
    task automatic back(input int abort_after, output bit aborted);
        int k = 0, cyc = 0;
        logic [DW-1:0] ed;
        aborted = 0;
        while (k < N && cyc < 200) begin
            ed = DW'($urandom);
            sf_out_ready = ($urandom_range(0, 3) != 0);
            sf_out_idx = IW'(k); sf_out_data = ed;
            #1;
            chk("back_ctrl", sf_backprop_ctrl, 1);
            chk("back_start", sf_start, sf_out_ready);
            chk("back_err_valid", err_valid, sf_out_ready);
            chk("back_pred_valid", pred_valid, 0);
            if (sf_out_ready) begin
                chk("back_err_idx", err_idx, k);
                chk("back_err_data", err_data, ed);
                k++;
            end
            tick();
            cyc++;
            if (abort_after > 0 && k == abort_after) begin
                sf_out_ready = 1; sf_out_idx = IW'(k); sf_in_ready = 1;
                rst = 0;
                #1;
                chk_reset_outputs("abort");
                tick();
                chk_reset_outputs("abort_edge");
                tick();
                rst = 1; sf_out_ready = 0; sf_in_ready = 0;
`ifdef SOFTMAX_CTRL_STATS_EN
                exp_runs = 0; exp_correct = 0;
`endif
                tick();
                aborted = 1;
                return;
            end
        end
        sf_out_ready = 0;
        chk("back_count", k, N);
    endtask

    task automatic done_check(input int am, input logic [IW-1:0] lab);
        sf_out_ready = 1; sf_out_idx = '0;
        #1;
        chk("done_pred_valid", pred_valid, 1);
        chk("done_pred", pred, am);
        chk("done_correct", correct, am == int'(lab));
        chk("done_timeout", timeout, 0);
        chk("done_backprop", sf_backprop_ctrl, 0);
        chk("done_err_valid", err_valid, 0);
`ifdef SOFTMAX_CTRL_STATS_EN
        exp_runs++;
        if (am == int'(lab)) exp_correct++;
`endif
        tick();
        sf_out_ready = 0;
        #1;
        chk("after_pred_valid", pred_valid, 0);
        chk("after_busy", busy, 0);
        tick();
    endtask

    task automatic run(input bit tr, input logic [IW-1:0] lab, input bit poke, input int abort_after);
        int am = argmax();
        bit ab = 0;
        start_run(tr, lab);
        load_scores();
        feed(poke);
        wait_max(am, poke);
        if (tr) back(abort_after, ab);
        if (!ab) done_check(am, lab);
    endtask

    task automatic timeout_run(input logic [IW-1:0] lab);
        int c = 0;
        start_run(0, lab);
        load_scores();
        sf_in_ready = 0;
        while (c <= 300) begin
            #1;
            if (pred_valid) break;
            chk("to_sf_start", sf_start, 0);
            tick();
            c++;
        end
        chk("to_latency", c, TO + 1);
        chk("to_timeout", timeout, 1);
        chk("to_correct", correct, 0);
        chk("to_sf_start_done", sf_start, 0);
`ifdef SOFTMAX_CTRL_STATS_EN
        exp_runs++;
`endif
        tick();
        #1;
        chk("to_after_pred_valid", pred_valid, 0);
        chk("to_after_busy", busy, 0);
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, want finish");
        $fatal(1);
    end

    initial begin
        rst = 0; run_start = 0; train = 0; label = '0; cur_label = '0;
        score_valid = 0; score_data = '0;
        sf_in_ready = 0; sf_max_ready = 0; sf_out_ready = 0;
        sf_max = '0; sf_out_idx = '0; sf_out_data = '0;
        repeat (3) tick();
        chk_reset_outputs("reset");
        rst = 1;
        tick();

        sc[0] = 32'h0000_8000; sc[1] = 32'h0001_0F00;
        sc[2] = 32'h0001_9E00; sc[3] = 32'h0002_2D00;
        run(0, 3'd0, 0, 0);
        run(1, 3'd3, 0, 0);
        timeout_run(3'd3);

        run(1, 3'd3, 0, 2);
        chk("post_abort_label", sf_expected_label, 0);
        run(1, 3'd1, 0, 0);
        run(0, 3'd3, 1, 0);

        for (int r = 0; r < 20; r++) begin
            bit tr;
            logic [IW-1:0] lab;
            for (int i = 0; i < N; i++) sc[i] = DW'($urandom);
            tr  = 1'($urandom_range(0, 1));
            lab = ($urandom_range(0, 1) != 0) ? IW'(argmax()) : IW'($urandom_range(0, N - 1));
            run(tr, lab, (r % 4) == 0, 0);
        end

`ifdef SOFTMAX_CTRL_STATS_EN
        chk("run_count", run_count, exp_runs);
        chk("correct_count", correct_count, exp_correct);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
